ce_axis_tx_arb: RTL

N-channel, packet-atomic AXI-stream arbiter. It merges TX completion/request streams from NUM_CH copy-engine instances onto the single PCIe SS TX stream (pcie_ss_axis_tx_if).
Generalises the one-engine-per-link topology to multiple engines, or PF/VF-partitioned engines, sharing one link.
Provides a registered output stage, selectable round-robin or fixed-priority arbitration, and per-channel packet counters.

---
 rtl/ce_axis_arb_pkg.sv | 17 +
 rtl/ce_arb_pick.sv | 42 ++++
 rtl/ce_axis_tx_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/ce_axis_arb_pkg.sv
// Shared types and constants for the copy-engine TX stream arbiter.
package ce_axis_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } t_arb_state;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Grant-id width: at least one bit, even for a single channel.
  function automatic int unsigned gid_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ce_arb_pick.sv
// Combinational request picker: round robin from ptr, or lowest index first.
module ce_arb_pick
  import ce_axis_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = gid_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              fixed,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  localparam int unsigned SW = IDX_W + 1;

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [SW-1:0]       base;
  logic [SW-1:0]       off;
  logic [SW-1:0]       sum;

  // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    base = fixed ? '0 : {1'b0, ptr};
    dbl  = {req, req} >> base;
    rot  = dbl[NUM_CH-1:0];
    any  = |req;
    off  = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (rot[i-1]) off = SW'(i - 1);
    end
    sum = off + base;
    if (sum >= SW'(NUM_CH)) sum = sum - SW'(NUM_CH);
    idx = IDX_W'(sum);
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      gnt[j] = any && (sum == SW'(j));
    end
  end

endmodule

// File: rtl/ce_axis_tx_arb.sv
// Packet-atomic N:1 AXI-stream arbiter with a registered output slice and
// per-channel packet counters.
module ce_axis_tx_arb
  import ce_axis_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned USER_W   = 10,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                          fim_clk,
  input  logic                          fim_rst_n,
  input  logic [NUM_CH-1:0]             s_tvalid,
  output logic [NUM_CH-1:0]             s_tready,
  input  logic [NUM_CH*DATA_W-1:0]      s_tdata,
  input  logic [NUM_CH*DATA_W/8-1:0]    s_tkeep,
  input  logic [NUM_CH*USER_W-1:0]      s_tuser,
  input  logic [NUM_CH-1:0]             s_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_W-1:0]             m_tdata,
  output logic [DATA_W/8-1:0]           m_tkeep,
  output logic [USER_W-1:0]             m_tuser,
  output logic                          m_tlast,
  output logic [gid_w(NUM_CH)-1:0]      grant_id,
  output logic                          busy,
  output logic [NUM_CH*CNT_W-1:0]       pkt_cnt
);

  localparam int unsigned GW = gid_w(NUM_CH);
  localparam int unsigned KW = DATA_W / 8;
  localparam logic        FIXED = (ARB_MODE == ARB_FIXED);

  t_arb_state                     state_q;
  logic [GW-1:0]                  grant_q, rr_q;
  logic                           mv_q, ml_q;
  logic [DATA_W-1:0]              md_q;
  logic [KW-1:0]                  mk_q;
  logic [USER_W-1:0]              mu_q;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q;

  logic [NUM_CH-1:0] pick_gnt, lock_oh, sel_oh;
  logic [GW-1:0]     pick_idx, sel, rr_nxt;
  logic              pick_any, load_ok, acc, last;

  ce_arb_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (GW)
  ) u_pick (
    .req   (s_tvalid),
    .ptr   (rr_q),
    .fixed (FIXED),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      lock_oh[i] = (grant_q == GW'(i));
    end
  end

  assign load_ok = ~mv_q | m_tready;
  assign sel     = (state_q == LOCKED) ? grant_q : pick_idx;
  assign sel_oh  = (state_q == LOCKED) ? lock_oh : pick_gnt;
  // Ready is forced low while reset is held so no beat is taken mid-reset.
  assign s_tready = fim_rst_n ? (sel_oh & {NUM_CH{load_ok}}) : '0;
  assign acc      = |(s_tvalid & s_tready);
  assign last     = s_tlast[sel];
  assign rr_nxt   = (sel == GW'(NUM_CH - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge fim_clk or negedge fim_rst_n) begin
    if (!fim_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      mv_q    <= 1'b0;
      md_q    <= '0;
      mk_q    <= '0;
      mu_q    <= '0;
      ml_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (load_ok) begin
        mv_q <= acc;
        if (acc) begin
          md_q <= s_tdata[sel*DATA_W +: DATA_W];
          mk_q <= s_tkeep[sel*KW +: KW];
          mu_q <= s_tuser[sel*USER_W +: USER_W];
          ml_q <= last;
        end
      end
      if (acc) begin
        grant_q <= sel;
        if (last) begin
          state_q    <= IDLE;
          cnt_q[sel] <= cnt_q[sel] + 1'b1;
          if (!FIXED) rr_q <= rr_nxt;
        end else begin
          state_q <= LOCKED;
        end
      end
    end
  end

  assign m_tvalid = mv_q;
  assign m_tdata  = md_q;
  assign m_tkeep  = mk_q;
  assign m_tuser  = mu_q;
  assign m_tlast  = ml_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == LOCKED);
  assign pkt_cnt  = cnt_q;

endmodule
